// File: rtl/passive_arm_ctrl_pkg.sv
// Shared definitions for the passive arming controller: state encodings and
// alarm-event counter width/saturation.
package passive_arm_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int EV_W    = 4;
    localparam int EV_MAX  = 15;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED = 3'd0,
        ST_ARMING   = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_t;

endpackage

// File: rtl/passive_delay_cnt.sv
// Loadable down counter shared by the timed alarm phases; holds at zero and
// flags it so the controller never sees a wrap.
module passive_delay_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] countReg;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            countReg <= '0;
        end else if (load) begin
            countReg <= loadVal;
        end else if (en && (countReg != '0)) begin
            countReg <= countReg - CNT_W'(1);
        end
    end

    assign zero = (countReg == '0);

endmodule

// File: rtl/passive_arm_ctrl.sv
// Passive car-alarm sequencer: disarmed -> arming countdown -> armed ->
// entry delay -> siren, with Moore outputs and a saturating alarm-event count.
module passive_arm_ctrl
    import passive_arm_ctrl_pkg::*;
#(
    parameter int ARM_DELAY    = 8,
    parameter int ENTRY_DELAY  = 6,
    parameter int SIREN_CYCLES = 10,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                PassiveSignal,
    input  logic                OpenDoorSign,
    input  logic                IgnitionSignalOn,
    input  logic                DisarmKey,
    output logic                ArmedSign,
    output logic                ArmingSign,
    output logic                EntryWarnSign,
    output logic                SirenSign,
    output logic [EV_W-1:0]     AlarmEvents,
    output logic [STATE_W-1:0]  StateOut
);

    localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(ARM_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

    state_t           stateReg;
    state_t           stateNext;
    logic             cntLoad;
    logic [CNT_W-1:0] cntLoadVal;
    logic             cntEn;
    logic             cntZero;
    logic             evInc;
    logic [EV_W-1:0]  eventsReg;

    passive_delay_cnt #(
        .CNT_W (CNT_W)
    ) delayCnt (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (cntLoad),
        .loadVal (cntLoadVal),
        .en      (cntEn),
        .zero    (cntZero)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            stateReg <= ST_DISARMED;
        end else begin
            stateReg <= stateNext;
        end
    end

    // DisarmKey is tested first in every state so it wins over all sensors.
    always_comb begin
        stateNext  = stateReg;
        cntLoad    = 1'b0;
        cntLoadVal = '0;
        cntEn      = 1'b0;
        evInc      = 1'b0;
        case (stateReg)
            ST_DISARMED: begin
                if (PassiveSignal && !IgnitionSignalOn && !OpenDoorSign && !DisarmKey) begin
                    stateNext  = ST_ARMING;
                    cntLoad    = 1'b1;
                    cntLoadVal = ARM_LOAD;
                end
            end
            ST_ARMING: begin
                if (DisarmKey || !PassiveSignal || IgnitionSignalOn || OpenDoorSign) begin
                    stateNext = ST_DISARMED;
                end else if (cntZero) begin
                    stateNext = ST_ARMED;
                end else begin
                    cntEn = 1'b1;
                end
            end
            ST_ARMED: begin
                if (DisarmKey) begin
                    stateNext = ST_DISARMED;
                end else if (OpenDoorSign) begin
                    stateNext  = ST_ENTRY;
                    cntLoad    = 1'b1;
                    cntLoadVal = ENTRY_LOAD;
                end else if (IgnitionSignalOn) begin
                    stateNext  = ST_ALARM;
                    cntLoad    = 1'b1;
                    cntLoadVal = SIREN_LOAD;
                    evInc      = 1'b1;
                end
            end
            ST_ENTRY: begin
                if (DisarmKey) begin
                    stateNext = ST_DISARMED;
                end else if (cntZero) begin
                    stateNext  = ST_ALARM;
                    cntLoad    = 1'b1;
                    cntLoadVal = SIREN_LOAD;
                    evInc      = 1'b1;
                end else begin
                    cntEn = 1'b1;
                end
            end
            ST_ALARM: begin
                if (DisarmKey) begin
                    stateNext = ST_DISARMED;
                end else if (cntZero) begin
                    // A still-open door or live ignition re-triggers the burst without a new event.
                    if (OpenDoorSign || IgnitionSignalOn) begin
                        cntLoad    = 1'b1;
                        cntLoadVal = SIREN_LOAD;
                    end else begin
                        stateNext = ST_ARMED;
                    end
                end else begin
                    cntEn = 1'b1;
                end
            end
            default: begin
                stateNext = ST_DISARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            eventsReg <= '0;
        end else if (evInc && (eventsReg != EV_W'(EV_MAX))) begin
            eventsReg <= eventsReg + EV_W'(1);
        end
    end

    always_comb begin
        ArmingSign    = (stateReg == ST_ARMING);
        ArmedSign     = (stateReg == ST_ARMED) || (stateReg == ST_ENTRY);
        EntryWarnSign = (stateReg == ST_ENTRY);
        SirenSign     = (stateReg == ST_ALARM);
    end

    assign AlarmEvents = eventsReg;
    assign StateOut    = stateReg;

endmodule

// File: tb/tb_passive_arm_ctrl.sv
// Directed scenarios plus random sensor traffic for passive_arm_ctrl, checked
// every cycle against a timestamp-based model of the alarm phases.
module tb_passive_arm_ctrl;

    localparam int ARM_D   = 4;
    localparam int ENTRY_D = 3;
    localparam int SIREN_D = 5;

    localparam int M_DIS = 0, M_ARMING = 1, M_ARMED = 2, M_ENTRY = 3, M_ALARM = 4;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       PassiveSignal = 1'b0;
    logic       OpenDoorSign = 1'b0;
    logic       IgnitionSignalOn = 1'b0;
    logic       DisarmKey = 1'b0;
    logic       ArmedSign, ArmingSign, EntryWarnSign, SirenSign;
    logic [3:0] AlarmEvents;
    logic [2:0] StateOut;

    int errors = 0;
    int checks = 0;
    int edgeNo = 0;
    int mState = M_DIS;
    int mEnter = 0;
    int mEvents = 0;

    passive_arm_ctrl #(
        .ARM_DELAY    (ARM_D),
        .ENTRY_DELAY  (ENTRY_D),
        .SIREN_CYCLES (SIREN_D),
        .CNT_W        (8)
    ) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .PassiveSignal    (PassiveSignal),
        .OpenDoorSign     (OpenDoorSign),
        .IgnitionSignalOn (IgnitionSignalOn),
        .DisarmKey        (DisarmKey),
        .ArmedSign        (ArmedSign),
        .ArmingSign       (ArmingSign),
        .EntryWarnSign    (EntryWarnSign),
        .SirenSign        (SirenSign),
        .AlarmEvents      (AlarmEvents),
        .StateOut         (StateOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edgeNo);
        end
    endtask

    task automatic chkAll(input string tag);
        chk({tag, ".StateOut"},      8'(StateOut),      8'(mState));
        chk({tag, ".ArmingSign"},    8'(ArmingSign),    8'(mState == M_ARMING));
        chk({tag, ".ArmedSign"},     8'(ArmedSign),     8'(mState == M_ARMED || mState == M_ENTRY));
        chk({tag, ".EntryWarnSign"}, 8'(EntryWarnSign), 8'(mState == M_ENTRY));
        chk({tag, ".SirenSign"},     8'(SirenSign),     8'(mState == M_ALARM));
        chk({tag, ".AlarmEvents"},   8'(AlarmEvents),   8'(mEvents));
    endtask

    // Phase timing is tracked as "edges since the phase was entered".
    task automatic modelStep();
        int age;
        age = edgeNo - mEnter;
        if (!reset_L) begin
            mState = M_DIS;
            mEvents = 0;
        end else begin
            case (mState)
                M_DIS: if (PassiveSignal && !IgnitionSignalOn && !OpenDoorSign && !DisarmKey) begin
                    mState = M_ARMING; mEnter = edgeNo;
                end
                M_ARMING: if (DisarmKey || !PassiveSignal || IgnitionSignalOn || OpenDoorSign) begin
                    mState = M_DIS;
                end else if (age == ARM_D) begin
                    mState = M_ARMED; mEnter = edgeNo;
                end
                M_ARMED: if (DisarmKey) begin
                    mState = M_DIS;
                end else if (OpenDoorSign) begin
                    mState = M_ENTRY; mEnter = edgeNo;
                end else if (IgnitionSignalOn) begin
                    mState = M_ALARM; mEnter = edgeNo;
                    mEvents = (mEvents < 15) ? mEvents + 1 : 15;
                end
                M_ENTRY: if (DisarmKey) begin
                    mState = M_DIS;
                end else if (age == ENTRY_D) begin
                    mState = M_ALARM; mEnter = edgeNo;
                    mEvents = (mEvents < 15) ? mEvents + 1 : 15;
                end
                M_ALARM: if (DisarmKey) begin
                    mState = M_DIS;
                end else if (age == SIREN_D) begin
                    if (OpenDoorSign || IgnitionSignalOn) mEnter = edgeNo;
                    else begin mState = M_ARMED; mEnter = edgeNo; end
                end
                default: mState = M_DIS;
            endcase
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        edgeNo++;
        modelStep();
        #1;
        chkAll(tag);
    endtask

    task automatic armUp();
        PassiveSignal = 1'b1; OpenDoorSign = 1'b0; IgnitionSignalOn = 1'b0; DisarmKey = 1'b0;
        for (int i = 0; i < ARM_D + 1; i++) tick("arm");
        chk("armUp.state", 8'(StateOut), 8'd2);
    endtask

    task automatic doReset();
        reset_L = 1'b0;
        #1;
        mState = M_DIS; mEvents = 0;
        chkAll("resetAsync");
        tick("resetHeld");
        reset_L = 1'b1;
    endtask

    initial begin
        #2;
        chkAll("por");
        #5 reset_L = 1'b1;

        // 1: arming countdown
        PassiveSignal = 1'b1;
        for (int i = 0; i < ARM_D; i++) begin
            tick("s1");
            chk("s1.arming", 8'(ArmingSign), 8'd1);
        end
        tick("s1");
        chk("s1.armed", 8'(StateOut), 8'd2);
        chk("s1.events", 8'(AlarmEvents), 8'd0);

        // 2: door during arming aborts, re-arm takes the full delay
        doReset();
        PassiveSignal = 1'b1;
        tick("s2"); tick("s2");
        OpenDoorSign = 1'b1;
        tick("s2");
        chk("s2.abort", 8'(StateOut), 8'd0);
        OpenDoorSign = 1'b0;
        armUp();

        // 3: disarm during entry
        OpenDoorSign = 1'b1;
        tick("s3"); tick("s3");
        OpenDoorSign = 1'b0; DisarmKey = 1'b1;
        tick("s3");
        DisarmKey = 1'b0; PassiveSignal = 1'b0;
        chk("s3.disarmed", 8'(StateOut), 8'd0);

        // 4: entry expires, one siren burst, back to armed
        doReset();
        armUp();
        OpenDoorSign = 1'b1;
        tick("s4");
        OpenDoorSign = 1'b0;
        for (int i = 0; i < ENTRY_D + SIREN_D; i++) tick("s4");
        chk("s4.rearmed", 8'(ArmedSign), 8'd1);
        chk("s4.events", 8'(AlarmEvents), 8'd1);

        // 5: ignition tamper held, siren across reloads
        doReset();
        armUp();
        IgnitionSignalOn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick("s5");
            chk("s5.siren", 8'(SirenSign), 8'd1);
        end
        DisarmKey = 1'b1;
        tick("s5");
        DisarmKey = 1'b0; IgnitionSignalOn = 1'b0;
        chk("s5.events", 8'(AlarmEvents), 8'd1);

        // 6: async reset mid-burst, then saturation
        doReset();
        armUp();
        IgnitionSignalOn = 1'b1;
        tick("s6"); tick("s6");
        #2;
        reset_L = 1'b0;
        #1;
        chk("s6.sirenAsync", 8'(SirenSign), 8'd0);
        mState = M_DIS; mEvents = 0;
        chkAll("s6.reset");
        IgnitionSignalOn = 1'b0;
        tick("s6");
        reset_L = 1'b1;
        for (int n = 0; n < 16; n++) begin
            armUp();
            IgnitionSignalOn = 1'b1;
            tick("s6t");
            IgnitionSignalOn = 1'b0; DisarmKey = 1'b1;
            tick("s6t");
            DisarmKey = 1'b0;
        end
        chk("s6.saturate", 8'(AlarmEvents), 8'd15);

        // random traffic
        doReset();
        for (int i = 0; i < 400; i++) begin
            PassiveSignal    = ($urandom % 10) < 8;
            OpenDoorSign     = ($urandom % 100) < 8;
            IgnitionSignalOn = ($urandom % 100) < 5;
            DisarmKey        = ($urandom % 100) < 4;
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
